pipeline_hazard_ctrl: RTL and testbench
=======================================

# pipeline_hazard_ctrl

Central stall/flush sequencer for the five-stage LEGv8 pipeline. It watches the IF/ID source registers, the ID/EX load destination, the MEM-stage branch resolution and the data-memory busy flag. From these it drives the PC write enable and the hold, flush and bubble controls of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. A small FSM handles multi-cycle load-use stalls and memory waits so that the pipeline registers stay simple clocked latches.

## Interface
- LU_STALL_CYCLES, 1, load-use stall length in cycles; legal range 1..4.
- clock  in  1  pipeline clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- ifid_rn  in  5  first source register, instruction[9:5] of the instruction in IF/ID.
- ifid_src2  in  5  second source register chosen by the decoder: Rm for R-format, Rt for STUR/CBZ.
- ifid_src2_valid  in  1  ifid_src2 is actually read.
- idex_memread  in  1  instruction in ID/EX is a load.
- idex_rd  in  5  destination register of the instruction in ID/EX.
- mem_branch_taken  in  1  branch resolved taken in MEM (Branch&Zero or Uncond_Branch).
- mem_busy  in  1  data memory is not finished this cycle.
- pc_write  out  1  PC may update.
- ifid_write  out  1  IF/ID may load.
- ifid_flush  out  1  IF/ID loads a NOP.
- idex_bubble  out  1  ID/EX control fields load zero.
- idex_hold  out  1  ID/EX keeps its contents.
- exmem_flush  out  1  EX/MEM control fields load zero.
- exmem_hold  out  1  EX/MEM keeps its contents.
- memwb_bubble  out  1  MEM/WB control fields load zero.
- state  out  2  current FSM state, for debug.

## Operation
- Load-use hazard (hz) = idex_memread and idex_rd != 31 (XZR), and either:
  - idex_rd == ifid_rn, or
  - ifid_src2_valid and idex_rd == ifid_src2.
- States:
  - RUN = 0
  - LU_STALL = 1
  - MEM_WAIT = 2
  - Encoding 3 is illegal and recovers to RUN.
- Priority within a cycle: reset > mem_branch_taken > mem_busy > hz/LU_STALL.
- Flush action: ifid_flush=1, idex_bubble=1, exmem_flush=1; PC is loaded with the branch target (pc_write=1).
- Stall action: pc_write=0, ifid_write=0, idex_bubble=1.
- Freeze action: pc_write=0, ifid_write=0, idex_hold=1, exmem_hold=1, memwb_bubble=1.
- Default action: pc_write=1, ifid_write=1, all other controls 0.
- RUN:
  - mem_branch_taken → flush action; stay in RUN.
  - Else mem_busy → freeze action; go to MEM_WAIT with ret=RUN.
  - Else hz → stall action; if LU_STALL_CYCLES>1, load cnt=LU_STALL_CYCLES-1 and go to LU_STALL.
- LU_STALL:
  - mem_branch_taken → flush action; cnt=0; go to RUN.
  - Else mem_busy → freeze action; cnt frozen; go to MEM_WAIT with ret=LU_STALL.
  - Else stall action; cnt decrements; go to RUN when cnt reaches 0.
- MEM_WAIT:
  - mem_branch_taken → flush action; go to RUN.
  - Else mem_busy=1 → freeze action.
  - Else (exit cycle) → outputs decoded as in state ret; next state follows ret's rules.
- cnt is 2 bits. It never wraps: decrement at 0 is forbidden, and the bench asserts this.

## Timing
- Outputs are combinational from registered state/cnt/ret plus the current inputs. They take effect at the same rising edge (zero latency).
- While reset=1:
  - state=RUN, cnt=0, ret=RUN.
  - pc_write=0, ifid_write=0.
  - ifid_flush=1, idex_bubble=1, exmem_flush=1, memwb_bubble=1.
  - idex_hold=0, exmem_hold=0.
- Reset asserted mid-stall or mid-wait aborts immediately with the values above.
- LU_STALL_CYCLES=1: a single stall cycle; the FSM stays in RUN, and the bubble clears hz on the next cycle.
- A new hz in the cycle after a stall ends is treated as a fresh hazard.

## Configuration
- PIPE_PERF_CNT_EN defined:
  - Adds outputs stall_cycles, flush_events and wait_cycles, each 32 bits.
  - Each counter increments once per cycle in which its action is driven.
  - Counters saturate at 0xFFFFFFFF and reset to 0.
- PIPE_PERF_CNT_EN undefined: these ports and their registers do not exist; all other behaviour is identical.

## Structure
- Shared package legv8_pipe_pkg holds:
  - the state enum (RUN/LU_STALL/MEM_WAIT);
  - the XZR=31 constant;
  - the LU_STALL_CYCLES limits.
- One sub-module: legv8_load_use_detect. It is purely combinational and computes hz from the five hazard inputs.

## Test plan
- Load hazard on Rn: idex_memread=1, idex_rd=5, ifid_rn=5 → one cycle with pc_write=0, ifid_write=0, idex_bubble=1; then default action.
- Load to XZR: idex_rd=31 matching ifid_src2 with ifid_src2_valid=1 → no stall.
- LU_STALL_CYCLES=3 and hz → three stall cycles. Then repeat with mem_busy=1 for 2 cycles during the second stall cycle → 2 freeze cycles, then the remaining 2 stall cycles.
- mem_branch_taken=1 together with hz and mem_busy=1 → flush action only; state=RUN next cycle.
- Reset asserted in MEM_WAIT → immediate reset output values; after release, default action with state=0.
- With PIPE_PERF_CNT_EN: 4 stall, 2 flush and 3 wait cycles → counters read 4/2/3. A forced saturation value holds at 0xFFFFFFFF.

Source files
------------

// File: rtl/legv8_pipe_pkg.sv
// Shared types and constants for the LEGv8 pipeline hazard sequencer.
package legv8_pipe_pkg;

   localparam int unsigned REG_W        = 5;
   localparam int unsigned CNT_W        = 2;
   localparam int unsigned PERF_W       = 32;
   localparam int unsigned LU_STALL_MIN = 1;
   localparam int unsigned LU_STALL_MAX = 4;

   localparam logic [REG_W-1:0] XZR = REG_W'(31);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      LU_STALL = 2'd1,
      MEM_WAIT = 2'd2
   } hz_state_e;

   // Pipeline-register control bundle driven every cycle
   typedef struct packed {
      logic pc_write;
      logic ifid_write;
      logic ifid_flush;
      logic idex_bubble;
      logic idex_hold;
      logic exmem_flush;
      logic exmem_hold;
      logic memwb_bubble;
   } pipe_ctrl_t;

   // Normal flow: PC and IF/ID advance, nothing else asserted
   function automatic pipe_ctrl_t ctrl_default();
      pipe_ctrl_t c;
      c            = '0;
      c.pc_write   = 1'b1;
      c.ifid_write = 1'b1;
      return c;
   endfunction

   // Taken branch: squash the three younger instructions, PC takes the target
   function automatic pipe_ctrl_t ctrl_flush();
      pipe_ctrl_t c;
      c             = ctrl_default();
      c.ifid_flush  = 1'b1;
      c.idex_bubble = 1'b1;
      c.exmem_flush = 1'b1;
      return c;
   endfunction

   // Load-use: hold PC and IF/ID, inject a bubble into ID/EX
   function automatic pipe_ctrl_t ctrl_stall();
      pipe_ctrl_t c;
      c             = '0;
      c.idex_bubble = 1'b1;
      return c;
   endfunction

   // Memory wait: freeze everything upstream of MEM, bubble into WB
   function automatic pipe_ctrl_t ctrl_freeze();
      pipe_ctrl_t c;
      c              = '0;
      c.idex_hold    = 1'b1;
      c.exmem_hold   = 1'b1;
      c.memwb_bubble = 1'b1;
      return c;
   endfunction

   // Values presented while reset is asserted
   function automatic pipe_ctrl_t ctrl_reset();
      pipe_ctrl_t c;
      c              = '0;
      c.ifid_flush   = 1'b1;
      c.idex_bubble  = 1'b1;
      c.exmem_flush  = 1'b1;
      c.memwb_bubble = 1'b1;
      return c;
   endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-controller signal bundle. Optional perf counters: PIPE_PERF_CNT_EN.
interface pipeline_hazard_ctrl_if;
   import legv8_pipe_pkg::*;

   logic [REG_W-1:0] ifid_rn;
   logic [REG_W-1:0] ifid_src2;
   logic             ifid_src2_valid;
   logic             idex_memread;
   logic [REG_W-1:0] idex_rd;
   logic             mem_branch_taken;
   logic             mem_busy;

   logic             pc_write;
   logic             ifid_write;
   logic             ifid_flush;
   logic             idex_bubble;
   logic             idex_hold;
   logic             exmem_flush;
   logic             exmem_hold;
   logic             memwb_bubble;
   logic [1:0]       state;
`ifdef PIPE_PERF_CNT_EN
   logic [PERF_W-1:0] stall_cycles;
   logic [PERF_W-1:0] flush_events;
   logic [PERF_W-1:0] wait_cycles;
`endif

   modport master (
      output ifid_rn, ifid_src2, ifid_src2_valid, idex_memread, idex_rd,
             mem_branch_taken, mem_busy,
      input  pc_write, ifid_write, ifid_flush, idex_bubble, idex_hold,
             exmem_flush, exmem_hold, memwb_bubble, state
`ifdef PIPE_PERF_CNT_EN
      , input stall_cycles, flush_events, wait_cycles
`endif
   );

   modport slave (
      input  ifid_rn, ifid_src2, ifid_src2_valid, idex_memread, idex_rd,
             mem_branch_taken, mem_busy,
      output pc_write, ifid_write, ifid_flush, idex_bubble, idex_hold,
             exmem_flush, exmem_hold, memwb_bubble, state
`ifdef PIPE_PERF_CNT_EN
      , output stall_cycles, flush_events, wait_cycles
`endif
   );

endinterface

// File: rtl/legv8_load_use_detect.sv
// Combinational load-use hazard detector between ID/EX load and IF/ID sources.
module legv8_load_use_detect
   import legv8_pipe_pkg::*;
(
   input  logic [REG_W-1:0] ifid_rn_i,
   input  logic [REG_W-1:0] ifid_src2_i,
   input  logic             ifid_src2_valid_i,
   input  logic             idex_memread_i,
   input  logic [REG_W-1:0] idex_rd_i,
   output logic             hz_c_o
);

   // A load into XZR never produces a value, so it cannot cause a hazard
   always_comb begin
      hz_c_o = idex_memread_i && (idex_rd_i != XZR) &&
               ((idex_rd_i == ifid_rn_i) ||
                (ifid_src2_valid_i && (idex_rd_i == ifid_src2_i)));
   end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the five-stage LEGv8 pipeline.
// Optional perf counters enabled by defining PIPE_PERF_CNT_EN.
module pipeline_hazard_ctrl
   import legv8_pipe_pkg::*;
#(
   parameter int unsigned LU_STALL_CYCLES = 1
) (
   input  logic                  clock,
   input  logic                  reset,
   pipeline_hazard_ctrl_if.slave hc
);

   // Out-of-range stall lengths are clamped into the supported window
   localparam int unsigned LU_N =
      (LU_STALL_CYCLES < LU_STALL_MIN) ? LU_STALL_MIN :
      (LU_STALL_CYCLES > LU_STALL_MAX) ? LU_STALL_MAX : LU_STALL_CYCLES;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LU_N - 1);

   hz_state_e        state_q, state_d;
   hz_state_e        ret_q, ret_d;
   hz_state_e        eff_state;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             hz_c;
   pipe_ctrl_t       ctrl_c;
   pipe_ctrl_t       out_c;

   legv8_load_use_detect u_lud (
      .ifid_rn_i         (hc.ifid_rn),
      .ifid_src2_i       (hc.ifid_src2),
      .ifid_src2_valid_i (hc.ifid_src2_valid),
      .idex_memread_i    (hc.idex_memread),
      .idex_rd_i         (hc.idex_rd),
      .hz_c_o            (hz_c)
   );

   // State, remaining-stall count and post-wait return state
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= RUN;
         cnt_q   <= '0;
         ret_q   <= RUN;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ret_q   <= ret_d;
      end
   end

   // Next state and control decode; a finished memory wait behaves as its return state
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      ret_d     = ret_q;
      ctrl_c    = ctrl_default();
      eff_state = (state_q == MEM_WAIT) ? ret_q : state_q;

      if (hc.mem_branch_taken) begin
         ctrl_c  = ctrl_flush();
         state_d = RUN;
         cnt_d   = '0;
         ret_d   = RUN;
      end else if (hc.mem_busy) begin
         ctrl_c  = ctrl_freeze();
         state_d = MEM_WAIT;
         if (state_q != MEM_WAIT) begin
            ret_d = (state_q == LU_STALL) ? LU_STALL : RUN;
         end
      end else begin
         case (eff_state)
            RUN: begin
               state_d = RUN;
               if (hz_c) begin
                  ctrl_c = ctrl_stall();
                  if (LU_N > 1) begin
                     cnt_d   = CNT_LOAD;
                     state_d = LU_STALL;
                  end
               end
            end
            LU_STALL: begin
               ctrl_c  = ctrl_stall();
               cnt_d   = cnt_q - CNT_W'(1);
               state_d = (cnt_d == '0) ? RUN : LU_STALL;
            end
            default: begin
               state_d = RUN;
               cnt_d   = '0;
               ret_d   = RUN;
            end
         endcase
      end
   end

   // Reset overrides the decoded controls immediately
   assign out_c = reset ? ctrl_reset() : ctrl_c;

   assign hc.pc_write     = out_c.pc_write;
   assign hc.ifid_write   = out_c.ifid_write;
   assign hc.ifid_flush   = out_c.ifid_flush;
   assign hc.idex_bubble  = out_c.idex_bubble;
   assign hc.idex_hold    = out_c.idex_hold;
   assign hc.exmem_flush  = out_c.exmem_flush;
   assign hc.exmem_hold   = out_c.exmem_hold;
   assign hc.memwb_bubble = out_c.memwb_bubble;
   assign hc.state        = state_q;

`ifdef PIPE_PERF_CNT_EN
   localparam logic [PERF_W-1:0] PERF_MAX = {PERF_W{1'b1}};

   logic [PERF_W-1:0] stall_cycles_q, flush_events_q, wait_cycles_q;
   logic              is_stall_c, is_flush_c, is_freeze_c;

   assign is_flush_c  = ctrl_c.ifid_flush;
   assign is_freeze_c = ctrl_c.idex_hold;
   assign is_stall_c  = ctrl_c.idex_bubble & ~ctrl_c.ifid_flush;

   // Saturating per-action cycle counters
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         stall_cycles_q <= '0;
         flush_events_q <= '0;
         wait_cycles_q  <= '0;
      end else begin
         if (is_stall_c && (stall_cycles_q != PERF_MAX)) begin
            stall_cycles_q <= stall_cycles_q + PERF_W'(1);
         end
         if (is_flush_c && (flush_events_q != PERF_MAX)) begin
            flush_events_q <= flush_events_q + PERF_W'(1);
         end
         if (is_freeze_c && (wait_cycles_q != PERF_MAX)) begin
            wait_cycles_q <= wait_cycles_q + PERF_W'(1);
         end
      end
   end

   assign hc.stall_cycles = stall_cycles_q;
   assign hc.flush_events = flush_events_q;
   assign hc.wait_cycles  = wait_cycles_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl with 1-cycle and 3-cycle load-use stalls.
module tb_pipeline_hazard_ctrl;

   // Expected control vectors, bit order:
   // pc_write ifid_write ifid_flush idex_bubble idex_hold exmem_flush exmem_hold memwb_bubble
   localparam logic [7:0] A_DEF    = 8'b1100_0000;
   localparam logic [7:0] A_FLUSH  = 8'b1111_0100;
   localparam logic [7:0] A_STALL  = 8'b0001_0000;
   localparam logic [7:0] A_FREEZE = 8'b0000_1011;
   localparam logic [7:0] A_RESET  = 8'b0011_0101;

   typedef struct packed {
`ifdef PIPE_PERF_CNT_EN
      logic [31:0] st;
      logic [31:0] fl;
      logic [31:0] wt;
`endif
      logic [7:0]  ctrl;
      logic [1:0]  state;
   } exp_t;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic [4:0] rn = '0, s2 = '0, rd = '0;
   logic       s2v = 1'b0, mr = 1'b0, br = 1'b0, busy = 1'b0;

   int vectors     = 0;
   int miscompares = 0;

   exp_t q0[$];
   exp_t q1[$];

   int          m_mode[2] = '{0, 0};
   int          m_left[2] = '{0, 0};
   int          m_ret[2]  = '{0, 0};
   int unsigned n_of[2]   = '{1, 3};
`ifdef PIPE_PERF_CNT_EN
   logic [31:0] m_st[2] = '{0, 0};
   logic [31:0] m_fl[2] = '{0, 0};
   logic [31:0] m_wt[2] = '{0, 0};
   bit          poke_sat = 1'b0;
`endif

   always #5 clock = ~clock;

   pipeline_hazard_ctrl_if if1 ();
   pipeline_hazard_ctrl_if if3 ();

   assign if1.ifid_rn = rn;          assign if3.ifid_rn = rn;
   assign if1.ifid_src2 = s2;        assign if3.ifid_src2 = s2;
   assign if1.ifid_src2_valid = s2v; assign if3.ifid_src2_valid = s2v;
   assign if1.idex_memread = mr;     assign if3.idex_memread = mr;
   assign if1.idex_rd = rd;          assign if3.idex_rd = rd;
   assign if1.mem_branch_taken = br; assign if3.mem_branch_taken = br;
   assign if1.mem_busy = busy;       assign if3.mem_busy = busy;

   pipeline_hazard_ctrl #(.LU_STALL_CYCLES(1)) dut1 (.clock(clock), .reset(reset), .hc(if1));
   pipeline_hazard_ctrl #(.LU_STALL_CYCLES(3)) dut3 (.clock(clock), .reset(reset), .hc(if3));

   function automatic bit model_hz(input logic [4:0] a_rn, input logic [4:0] a_s2,
                                   input bit a_v, input bit a_mr, input logic [4:0] a_rd);
      if (!a_mr || a_rd == 5'd31) return 1'b0;
      return (a_rd == a_rn) || (a_v && a_rd == a_s2);
   endfunction

   // Reference: mode 0 = running, 1 = stalling (m_left more after this), 2 = waiting on memory
   task automatic model_step(input int d, input bit r, input bit hzv, input bit a_br, input bit a_busy);
      exp_t       e;
      logic [7:0] act;
      int         eff;
      e = '0;
      if (r) begin
         act = A_RESET;
         m_mode[d] = 0; m_left[d] = 0; m_ret[d] = 0;
`ifdef PIPE_PERF_CNT_EN
         m_st[d] = 0; m_fl[d] = 0; m_wt[d] = 0;
`endif
      end else begin
         e.state = 2'(m_mode[d]);
`ifdef PIPE_PERF_CNT_EN
         e.st = m_st[d]; e.fl = m_fl[d]; e.wt = m_wt[d];
`endif
         eff = (m_mode[d] == 2) ? m_ret[d] : m_mode[d];
         if (a_br) begin
            act = A_FLUSH; m_mode[d] = 0; m_left[d] = 0;
         end else if (a_busy) begin
            act = A_FREEZE;
            if (m_mode[d] != 2) m_ret[d] = m_mode[d];
            m_mode[d] = 2;
         end else if (eff == 1) begin
            act = A_STALL;
            m_left[d] = m_left[d] - 1;
            m_mode[d] = (m_left[d] == 0) ? 0 : 1;
         end else if (hzv) begin
            act = A_STALL;
            if (n_of[d] > 1) begin
               m_left[d] = int'(n_of[d]) - 1;
               m_mode[d] = 1;
            end else begin
               m_mode[d] = 0;
            end
         end else begin
            act = A_DEF; m_mode[d] = 0;
         end
`ifdef PIPE_PERF_CNT_EN
         if (act == A_STALL  && m_st[d] != 32'hFFFF_FFFF) m_st[d] = m_st[d] + 1;
         if (act == A_FLUSH  && m_fl[d] != 32'hFFFF_FFFF) m_fl[d] = m_fl[d] + 1;
         if (act == A_FREEZE && m_wt[d] != 32'hFFFF_FFFF) m_wt[d] = m_wt[d] + 1;
`endif
      end
      e.ctrl = act;
      if (d == 0) q0.push_back(e); else q1.push_back(e);
   endtask

   // Drive one cycle of inputs just after the rising edge and queue expectations
   task automatic cyc(input bit r, input logic [4:0] a_rn, input logic [4:0] a_s2, input bit a_v,
                      input bit a_mr, input logic [4:0] a_rd, input bit a_br, input bit a_busy);
      @(posedge clock);
      #1;
`ifdef PIPE_PERF_CNT_EN
      if (poke_sat) begin
         force dut1.stall_cycles_q = 32'hFFFF_FFFE;
         #1;
         release dut1.stall_cycles_q;
         m_st[0]  = 32'hFFFF_FFFE;
         poke_sat = 1'b0;
      end
`endif
      reset = r; rn = a_rn; s2 = a_s2; s2v = a_v; mr = a_mr; rd = a_rd; br = a_br; busy = a_busy;
      model_step(0, r, model_hz(a_rn, a_s2, a_v, a_mr, a_rd), a_br, a_busy);
      model_step(1, r, model_hz(a_rn, a_s2, a_v, a_mr, a_rd), a_br, a_busy);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
   endtask

   function automatic exp_t sample(input int d);
      exp_t a;
      a = '0;
      if (d == 0) begin
         a.ctrl  = {if1.pc_write, if1.ifid_write, if1.ifid_flush, if1.idex_bubble,
                    if1.idex_hold, if1.exmem_flush, if1.exmem_hold, if1.memwb_bubble};
         a.state = if1.state;
`ifdef PIPE_PERF_CNT_EN
         a.st = if1.stall_cycles; a.fl = if1.flush_events; a.wt = if1.wait_cycles;
`endif
      end else begin
         a.ctrl  = {if3.pc_write, if3.ifid_write, if3.ifid_flush, if3.idex_bubble,
                    if3.idex_hold, if3.exmem_flush, if3.exmem_hold, if3.memwb_bubble};
         a.state = if3.state;
`ifdef PIPE_PERF_CNT_EN
         a.st = if3.stall_cycles; a.fl = if3.flush_events; a.wt = if3.wait_cycles;
`endif
      end
      return a;
   endfunction

   task automatic check(input string nm, input exp_t e, input exp_t a);
      vectors++;
      if (a !== e) begin
         miscompares++;
         $display("FAIL %s @%0t: got ctrl=%b state=%0d (%h), expected ctrl=%b state=%0d (%h)",
                  nm, $time, a.ctrl, a.state, a, e.ctrl, e.state, e);
      end
   endtask

   // Monitor: compare DUT outputs mid-cycle against queued expectations
   initial begin
      exp_t e;
      forever begin
         @(negedge clock);
         if (q0.size() > 0) begin
            e = q0.pop_front();
            check("lu1", e, sample(0));
         end
         if (q1.size() > 0) begin
            e = q1.pop_front();
            check("lu3", e, sample(1));
         end
         if (if3.state == 2'd1) begin
            vectors++;
            if (dut3.cnt_q == 2'd0) begin
               miscompares++;
               $display("FAIL cnt_zero @%0t: got cnt=0 in LU_STALL, required nonzero", $time);
            end
         end
      end
   end

   initial begin
      // Reset
      cyc(1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
      cyc(1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
      idle(2);
      // Load hazard on Rn
      cyc(0, 5'd5, 5'd7, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0);
      idle(4);
      // Loads into XZR never stall
      cyc(0, 5'd3, 5'd31, 1'b1, 1'b1, 5'd31, 1'b0, 1'b0);
      cyc(0, 5'd31, 5'd4, 1'b0, 1'b1, 5'd31, 1'b0, 1'b0);
      idle(1);
      // Hazard on src2, ignored when src2 is not read
      cyc(0, 5'd5, 5'd7, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0);
      cyc(0, 5'd5, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0);
      idle(4);
      // Memory wait during the second stall cycle
      cyc(0, 5'd9, 5'd2, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0);
      cyc(0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
      cyc(0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
      idle(4);
      // Branch beats busy and hazard, also from inside a stall
      cyc(0, 5'd5, 5'd7, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1);
      idle(1);
      cyc(0, 5'd5, 5'd7, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0);
      cyc(0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
      idle(2);
      // Back-to-back hazards are fresh hazards
      for (int i = 0; i < 4; i++) cyc(0, 5'd6, 5'd7, 1'b0, 1'b1, 5'd6, 1'b0, 1'b0);
      idle(3);
      // Reset while waiting on memory
      cyc(0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
      cyc(0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
      cyc(1, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
      idle(2);
`ifdef PIPE_PERF_CNT_EN
      // Counter run: 4 stall, 2 flush, 3 wait cycles on the 1-cycle DUT, then saturation
      cyc(1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) cyc(0, 5'd8, 5'd2, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0);
      for (int i = 0; i < 2; i++) cyc(0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) cyc(0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
      idle(2);
      poke_sat = 1'b1;
      for (int i = 0; i < 3; i++) cyc(0, 5'd8, 5'd2, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0);
      idle(2);
`endif
      // Randomized traffic
      for (int i = 0; i < 800; i++) begin
         logic [4:0] a_rn, a_s2, a_rd;
         int         pick;
         a_rn = 5'($urandom_range(0, 31));
         a_s2 = 5'($urandom_range(0, 31));
         pick = int'($urandom_range(0, 3));
         a_rd = (pick == 0) ? a_rn : (pick == 1) ? a_s2 : (pick == 2) ? 5'd31 : 5'($urandom_range(0, 31));
         cyc(($urandom_range(0, 99) == 0), a_rn, a_s2, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             a_rd, ($urandom_range(0, 9) == 0), ($urandom_range(0, 4) == 0));
      end
      idle(1);
      repeat (2) @(negedge clock);
      vectors++;
      if (q0.size() != 0 || q1.size() != 0) begin
         miscompares++;
         $display("FAIL drain: got %0d/%0d pending expectations, required 0/0", q0.size(), q1.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
